hamming_tx_serializer: RTL and testbench



---
 rtl/hamming_pkg.sv | 36 +++
 rtl/hamming_enc12.sv | 32 +++
 rtl/hamming_tx_serializer.sv | 113 +++++++++++
 tb/tb_hamming_tx_serializer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions: widths, parity positions, coverage masks, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package hamming_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;

  // Parity bit positions within the 1-based codeword
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;
  localparam int P8_POS = 8;

  // Coverage masks, indexed [1:12] so position 1 is the MSB.
  // Each mask includes its own parity position, which is zero before parity is filled in.
  localparam logic [1:CODE_W] P1_MASK = 12'b101010101010; // 1,3,5,7,9,11
  localparam logic [1:CODE_W] P2_MASK = 12'b011001100110; // 2,3,6,7,10,11
  localparam logic [1:CODE_W] P4_MASK = 12'b000111100001; // 4,5,6,7,12
  localparam logic [1:CODE_W] P8_MASK = 12'b000000011111; // 8,9,10,11,12

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } txState_e;

  // One-hot mask selecting a single codeword position; positions outside 1..12 give zero
  function automatic logic [1:CODE_W] posMask(input logic [3:0] pos);
    posMask = '0;
    if (pos >= 4'd1 && pos <= 4'd12) begin
      posMask = 12'b100000000000 >> (pos - 4'd1);
    end
  endfunction

endpackage

// File: rtl/hamming_enc12.sv
// Hamming(12,8) even-parity encoder, data byte to 12-bit codeword (position 1 = MSB).
// Latency: purely combinational.
// Backpressure: none.
module hamming_enc12
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] dataIn,
  output logic [1:CODE_W]   codeOut
);

  logic [1:CODE_W] rawWord;

  // Place data bits, then fill each parity slot with the xor of the positions it covers
  always_comb begin
    rawWord     = '0;
    rawWord[3]  = dataIn[7];
    rawWord[5]  = dataIn[6];
    rawWord[6]  = dataIn[5];
    rawWord[7]  = dataIn[4];
    rawWord[9]  = dataIn[3];
    rawWord[10] = dataIn[2];
    rawWord[11] = dataIn[1];
    rawWord[12] = dataIn[0];

    codeOut         = rawWord;
    codeOut[P1_POS] = ^(rawWord & P1_MASK);
    codeOut[P2_POS] = ^(rawWord & P2_MASK);
    codeOut[P4_POS] = ^(rawWord & P4_MASK);
    codeOut[P8_POS] = ^(rawWord & P8_MASK);
  end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Encodes one byte per handshake into a 12-bit Hamming word and shifts it out, position 1 first.
// Latency: first serial bit 1 cycle after capture; frame 12*BIT_CYCLES, then IDLE_GAP idle cycles.
// Backpressure: in_ready is low for the whole frame plus gap; optional macro HAMMING_ERR_INJECT_EN.
module hamming_tx_serializer
  import hamming_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned IDLE_GAP   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic              err_en,
  input  logic [3:0]        err_pos,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_first,
  output logic              ser_last,
  output logic [1:CODE_W]   code_word,
  output logic              code_valid
);

  localparam logic [7:0] CYC_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(IDLE_GAP - 1);
  localparam bit         HAS_GAP  = (IDLE_GAP != 0);

  txState_e        state, nextState;
  logic [1:CODE_W] encWord, txWord, injMask, shiftReg, codeWordQ;
  logic [7:0]      cycCnt, gapCnt;
  logic [3:0]      bitCnt;
  logic            codeValidQ;
  logic            capture, bitDone, frameDone;

  hamming_enc12 uEnc (
    .dataIn  (in_data),
    .codeOut (encWord)
  );

`ifdef HAMMING_ERR_INJECT_EN
  assign injMask = err_en ? posMask(err_pos) : '0;
`else
  assign injMask = '0;
`endif

  assign txWord    = encWord ^ injMask;
  assign capture   = (state == IDLE) && in_valid;
  assign bitDone   = (cycCnt == CYC_LAST);
  assign frameDone = bitDone && (bitCnt == 4'(CODE_W));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state: capture starts a frame, last bit ends it, optional gap before accepting again
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = SHIFT;
      SHIFT:   if (frameDone) nextState = HAS_GAP ? GAP : IDLE;
      GAP:     if (gapCnt == GAP_LAST) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath: capture word, pace bits with cycCnt, step positions with bitCnt, count gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg   <= '0;
      codeWordQ  <= '0;
      codeValidQ <= 1'b0;
      cycCnt     <= '0;
      bitCnt     <= '0;
      gapCnt     <= '0;
    end else begin
      codeValidQ <= capture;
      if (capture) begin
        shiftReg  <= txWord;
        codeWordQ <= txWord;
        cycCnt    <= '0;
        bitCnt    <= 4'd1;
      end else if (state == SHIFT) begin
        if (bitDone) begin
          cycCnt   <= '0;
          shiftReg <= shiftReg << 1;
          bitCnt   <= frameDone ? 4'd0 : bitCnt + 4'd1;
          gapCnt   <= '0;
        end else begin
          cycCnt <= cycCnt + 8'd1;
        end
      end else if (state == GAP) begin
        gapCnt <= (gapCnt == GAP_LAST) ? 8'd0 : gapCnt + 8'd1;
      end
    end
  end

  // Outputs decoded from registered state only, so in_ready never depends on in_valid
  always_comb begin
    in_ready   = (state == IDLE);
    ser_valid  = (state == SHIFT);
    ser_out    = (state == SHIFT) && shiftReg[1];
    ser_first  = (state == SHIFT) && (bitCnt == 4'd1);
    ser_last   = (state == SHIFT) && (bitCnt == 4'(CODE_W));
    code_word  = codeWordQ;
    code_valid = codeValidQ;
  end

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Directed bench for hamming_tx_serializer: default instance (1 cycle/bit, no gap) and a slow one.
// Latency: n/a.
// Backpressure: stimulus waits on in_ready with bounded loops.
module tb_hamming_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValidA = 1'b0;
  logic        inValidB = 1'b0;
  logic [7:0]  inData = 8'h00;
`ifdef HAMMING_ERR_INJECT_EN
  logic        errEn = 1'b0;
  logic [3:0]  errPos = 4'd0;
`endif

  logic        inReadyA, serOutA, serValidA, serFirstA, serLastA, codeValidA;
  logic [1:12] codeWordA;
  logic        inReadyB, serOutB, serValidB, serFirstB, serLastB, codeValidB;
  logic [1:12] codeWordB;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hamming_tx_serializer dutA (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef HAMMING_ERR_INJECT_EN
    .err_en     (errEn),
    .err_pos    (errPos),
`endif
    .in_valid   (inValidA),
    .in_data    (inData),
    .in_ready   (inReadyA),
    .ser_out    (serOutA),
    .ser_valid  (serValidA),
    .ser_first  (serFirstA),
    .ser_last   (serLastA),
    .code_word  (codeWordA),
    .code_valid (codeValidA)
  );

  hamming_tx_serializer #(.BIT_CYCLES(3), .IDLE_GAP(2)) dutB (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef HAMMING_ERR_INJECT_EN
    .err_en     (1'b0),
    .err_pos    (4'd0),
`endif
    .in_valid   (inValidB),
    .in_data    (inData),
    .in_ready   (inReadyB),
    .ser_out    (serOutB),
    .ser_valid  (serValidB),
    .ser_first  (serFirstB),
    .ser_last   (serLastB),
    .code_word  (codeWordB),
    .code_valid (codeValidB)
  );

  // Offer a byte to instance A; returns on the first cycle of its frame with in_valid still high
  task automatic sendA(input logic [7:0] d);
    int waited = 0;
    @(negedge clk);
    inData   = d;
    inValidA = 1'b1;
    while (!inReadyA && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!inReadyA) begin
      vectors++;
      miscompares++;
      $display("FAIL sendA_timeout: in_ready=%b after %0d cycles, required 1", inReadyA, waited);
    end
    @(negedge clk);
  endtask

  // Gather instance A's serial word until in_ready returns; counts busy and bit cycles
  task automatic collectA(output logic [11:0] word, output int low, output int ser);
    word = '0;
    low  = 0;
    ser  = 0;
    while (!inReadyA && low < 200) begin
      if (serValidA) begin
        word = {word[10:0], serOutA};
        ser++;
      end
      low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({inReadyA, serOutA, serValidA, serFirstA, serLastA, codeValidA} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: {rdy,out,vld,first,last,cvld}=%b, required 100000",
               {inReadyA, serOutA, serValidA, serFirstA, serLastA, codeValidA});
    end
    vectors++;
    if (codeWordA !== 12'b0) begin
      miscompares++;
      $display("FAIL reset_code_word: got %b, required %b", codeWordA, 12'b0);
    end
    vectors++;
    if ({inReadyB, serValidB, codeWordB} !== {2'b10, 12'b0}) begin
      miscompares++;
      $display("FAIL reset_slow: rdy=%b vld=%b word=%b, required 1 0 0", inReadyB, serValidB, codeWordB);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [11:0] exp = 12'b010000010100;
    sendA(8'b00000100);
    inValidA = 1'b0;
    vectors++;
    if (codeValidA !== 1'b1 || codeWordA !== exp) begin
      miscompares++;
      $display("FAIL basic_code: valid=%b word=%b, required 1 %b", codeValidA, codeWordA, exp);
    end
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if ({serValidA, serOutA, serFirstA, serLastA, inReadyA} !==
          {1'b1, exp[11-i], (i == 0), (i == 11), 1'b0}) begin
        miscompares++;
        $display("FAIL basic_bit%0d: {vld,out,first,last,rdy}=%b, required %b", i + 1,
                 {serValidA, serOutA, serFirstA, serLastA, inReadyA},
                 {1'b1, exp[11-i], (i == 0), (i == 11), 1'b0});
      end
      @(negedge clk);
    end
    vectors++;
    if ({serValidA, inReadyA, codeValidA} !== 3'b010 || codeWordA !== exp) begin
      miscompares++;
      $display("FAIL basic_after: vld=%b rdy=%b cvld=%b word=%b, required 0 1 0 %b",
               serValidA, inReadyA, codeValidA, codeWordA, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] w;
    int low, ser;
    sendA(8'b00001001);
    inData = 8'b01010110;
    collectA(w, low, ser);
    vectors++;
    if (w !== 12'b100100001001 || low != 12 || ser != 12) begin
      miscompares++;
      $display("FAIL b2b_first: word=%b busy=%0d bits=%0d, required 100100001001 12 12", w, low, ser);
    end
    @(negedge clk);
    inValidA = 1'b0;
    // p2 = pos3^pos6^pos7^pos10^pos11 = 0^0^1^1^1 = 1
    vectors++;
    if (codeValidA !== 1'b1 || codeWordA !== 12'b110010100110) begin
      miscompares++;
      $display("FAIL b2b_second_capture: cvld=%b word=%b, required 1 110010100110", codeValidA, codeWordA);
    end
    collectA(w, low, ser);
    vectors++;
    if (w !== 12'b110010100110 || low != 12) begin
      miscompares++;
      $display("FAIL b2b_second: word=%b busy=%0d, required 110010100110 12", w, low);
    end
  endtask

  task automatic test_slow_gap();
    logic [11:0] exp = 12'b111011101111;
    int i = 0;
    @(negedge clk);
    vectors++;
    if (inReadyB !== 1'b1) begin
      miscompares++;
      $display("FAIL slow_ready_idle: got %b, required 1", inReadyB);
    end
    inData   = 8'hFF;
    inValidB = 1'b1;
    @(negedge clk);
    inValidB = 1'b0;
    vectors++;
    if (codeValidB !== 1'b1 || codeWordB !== exp) begin
      miscompares++;
      $display("FAIL slow_code: cvld=%b word=%b, required 1 %b", codeValidB, codeWordB, exp);
    end
    while (!inReadyB && i < 200) begin
      vectors++;
      if (i < 36) begin
        if ({serValidB, serOutB, serFirstB, serLastB} !== {1'b1, exp[11-i/3], (i < 3), (i >= 33)}) begin
          miscompares++;
          $display("FAIL slow_cycle%0d: {vld,out,first,last}=%b, required %b", i,
                   {serValidB, serOutB, serFirstB, serLastB}, {1'b1, exp[11-i/3], (i < 3), (i >= 33)});
        end
      end else if ({serValidB, serOutB} !== 2'b00) begin
        miscompares++;
        $display("FAIL slow_gap%0d: vld=%b out=%b, required 0 0", i, serValidB, serOutB);
      end
      i++;
      @(negedge clk);
    end
    vectors++;
    if (i != 38) begin
      miscompares++;
      $display("FAIL slow_busy_len: in_ready low %0d cycles, required 38", i);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] w;
    int low, ser;
    sendA(8'hA5);
    inValidA = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (serValidA !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: ser_valid=%b, required 1", serValidA);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({serValidA, inReadyA, serOutA, serFirstA, serLastA} !== 5'b01000 || codeWordA !== 12'b0) begin
      miscompares++;
      $display("FAIL midrst_async: {vld,rdy,out,first,last}=%b word=%b, required 01000 0",
               {serValidA, inReadyA, serOutA, serFirstA, serLastA}, codeWordA);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sendA(8'b01010110);
    inValidA = 1'b0;
    collectA(w, low, ser);
    vectors++;
    if (w !== 12'b110010100110 || codeWordA !== 12'b110010100110 || low != 12) begin
      miscompares++;
      $display("FAIL midrst_next: serial=%b word=%b busy=%0d, required 110010100110 x2 12", w, codeWordA, low);
    end
  endtask

  task automatic test_hold_valid();
    int low = 0;
    logic [11:0] w = '0;
    sendA(8'hA5);
    while (!inReadyA && low < 200) begin
      if (serValidA) w = {w[10:0], serOutA};
      inData = inData + 8'h13;
      low++;
      @(negedge clk);
    end
    inValidA = 1'b0;
    vectors++;
    if (w !== 12'b111001000101 || codeWordA !== 12'b111001000101 || low != 12) begin
      miscompares++;
      $display("FAIL hold_valid: serial=%b word=%b busy=%0d, required 111001000101 x2 12", w, codeWordA, low);
    end
    @(negedge clk);
    vectors++;
    if ({serValidA, codeValidA, inReadyA} !== 3'b001) begin
      miscompares++;
      $display("FAIL hold_valid_idle: {vld,cvld,rdy}=%b, required 001", {serValidA, codeValidA, inReadyA});
    end
  endtask

`ifdef HAMMING_ERR_INJECT_EN
  task automatic test_err_inject();
    logic [11:0] w;
    int low, ser;
    logic [3:0]  posTab [3] = '{4'd1, 4'd14, 4'd12};
    logic [11:0] expTab [3] = '{12'b110000010100, 12'b010000010100, 12'b010000010101};
    for (int k = 0; k < 3; k++) begin
      errEn  = 1'b1;
      errPos = posTab[k];
      sendA(8'b00000100);
      inValidA = 1'b0;
      errEn    = 1'b0;
      collectA(w, low, ser);
      vectors++;
      if (w !== expTab[k] || codeWordA !== expTab[k]) begin
        miscompares++;
        $display("FAIL err_inject_pos%0d: serial=%b word=%b, required %b", posTab[k], w, codeWordA, expTab[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_slow_gap();
    test_reset_mid_frame();
    test_hold_valid();
`ifdef HAMMING_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
